multi_cycle_control_fsm: RTL and testbench

- Sequencing controller for the multi-cycle RV32I datapath. Replaces per-instruction combinational control with a state machine.
- Steps each instruction through fetch, decode, execute, memory and write-back.
- Drives PC, IR, ALU-source, memory and register-file strobes from the current state plus the IR opcode.
- Stalls in memory states on a ready handshake.
- Stops permanently on a halting ECALL.

---
 rtl/multi_cycle_control_fsm_pkg.sv | 59 +++++
 rtl/multi_cycle_control_fsm_output_decoder.sv | 90 +++++++++
 rtl/multi_cycle_control_fsm.sv | 119 +++++++++++
 tb/tb_multi_cycle_control_fsm.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_cycle_control_fsm_pkg.sv
// Shared encodings for the multi-cycle RV32I controller: states, mux selects,
// ALU operation classes, opcodes and the packed strobe bundle.
package multi_cycle_control_fsm_pkg;

    typedef enum logic [2:0] {
        ST_INIT   = 3'd0,
        ST_IF     = 3'd1,
        ST_ID     = 3'd2,
        ST_EX     = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_PC_INC = 3'd6,
        ST_HALT   = 3'd7
    } state_t;

    localparam logic [1:0] WB_ALUOUT    = 2'd0;
    localparam logic [1:0] WB_MDR       = 2'd1;
    localparam logic [1:0] WB_PC4       = 2'd2;

    localparam logic [1:0] SRCB_B       = 2'd0;
    localparam logic [1:0] SRCB_FOUR    = 2'd1;
    localparam logic [1:0] SRCB_IMM     = 2'd2;

    localparam logic [1:0] ALUOP_ADD    = 2'd0;
    localparam logic [1:0] ALUOP_FUNCT  = 2'd1;
    localparam logic [1:0] ALUOP_BRANCH = 2'd2;

    localparam logic SRCA_PC      = 1'b0;
    localparam logic SRCA_REG     = 1'b1;
    localparam logic PCSRC_ALU    = 1'b0;
    localparam logic PCSRC_ALUOUT = 1'b1;
    localparam logic ADDR_PC      = 1'b0;
    localparam logic ADDR_ALUOUT  = 1'b1;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IARITH = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef struct packed {
        logic       pc_write;
        logic       pc_source;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] wb_sel;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       halted;
    } ctrl_t;

endpackage

// File: rtl/multi_cycle_control_fsm_output_decoder.sv
// Pure combinational map from (state, opcode, alu_bcond, mem_ready) to the
// datapath strobes; anything not driven for a state stays 0.
module mc_output_decoder
    import multi_cycle_control_fsm_pkg::*;
(
    input  state_t     state,
    input  logic [6:0] opcode,
    input  logic       alu_bcond,
    input  logic       mem_ready,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            ST_IF: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = ADDR_PC;
                ctrl.ir_write = mem_ready;
            end
            ST_ID: begin
                ctrl.alu_src_a = SRCA_PC;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            ST_EX: begin
                case (opcode)
                    OP_RTYPE: begin
                        ctrl.alu_src_a = SRCA_REG;
                        ctrl.alu_src_b = SRCB_B;
                        ctrl.alu_op    = ALUOP_FUNCT;
                    end
                    OP_IARITH: begin
                        ctrl.alu_src_a = SRCA_REG;
                        ctrl.alu_src_b = SRCB_IMM;
                        ctrl.alu_op    = ALUOP_FUNCT;
                    end
                    OP_LOAD, OP_STORE, OP_JALR: begin
                        ctrl.alu_src_a = SRCA_REG;
                        ctrl.alu_src_b = SRCB_IMM;
                        ctrl.alu_op    = ALUOP_ADD;
                    end
                    OP_BRANCH: begin
                        ctrl.alu_src_a = SRCA_REG;
                        ctrl.alu_src_b = SRCB_B;
                        ctrl.alu_op    = ALUOP_BRANCH;
                        ctrl.pc_write  = alu_bcond;
                        ctrl.pc_source = alu_bcond ? PCSRC_ALUOUT : PCSRC_ALU;
                    end
                    OP_JAL: begin
                        // ALU computes PC+4 for rd while PC loads the target from ALUOut.
                        ctrl.alu_src_a = SRCA_PC;
                        ctrl.alu_src_b = SRCB_FOUR;
                        ctrl.reg_write = 1'b1;
                        ctrl.wb_sel    = WB_PC4;
                        ctrl.pc_write  = 1'b1;
                        ctrl.pc_source = PCSRC_ALUOUT;
                    end
                    default: ;
                endcase
            end
            ST_MEM: begin
                ctrl.i_or_d    = ADDR_ALUOUT;
                ctrl.mem_read  = (opcode == OP_LOAD);
                ctrl.mem_write = (opcode == OP_STORE);
            end
            ST_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src_a = SRCA_PC;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.pc_write  = 1'b1;
                if (opcode == OP_LOAD) begin
                    ctrl.wb_sel = WB_MDR;
                end else if (opcode == OP_JALR) begin
                    ctrl.wb_sel    = WB_PC4;
                    ctrl.pc_source = PCSRC_ALUOUT;
                end
            end
            ST_PC_INC: begin
                ctrl.alu_src_a = SRCA_PC;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_ALU;
            end
            ST_HALT: ctrl.halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/multi_cycle_control_fsm.sv
// Multi-cycle RV32I sequencing FSM. Optional performance counters are built
// only when CONTROL_PERF_CNT_EN is defined; otherwise both ports read 0.
//
// state   | meaning
// INIT    | post-reset idle, all strobes low
// IF      | fetch from PC, wait for mem_ready
// ID      | decode, ALUOut <= PC + imm
// EX      | execute / address / branch resolve
// MEM     | data access, held until mem_ready
// WB      | register-file write, PC update
// PC_INC  | PC <= PC + 4 for instructions without writeback
// HALT    | halting ECALL seen, absorbing until reset
module multi_cycle_control_fsm
    import multi_cycle_control_fsm_pkg::*;
#(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [6:0]           opcode,
    input  logic                 alu_bcond,
    input  logic                 is_halted,
    input  logic                 mem_ready,
    output logic                 pc_write,
    output logic                 pc_source,
    output logic                 i_or_d,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 ir_write,
    output logic                 reg_write,
    output logic [1:0]           wb_sel,
    output logic                 alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [1:0]           alu_op,
    output logic                 halted,
    output logic [CNT_WIDTH-1:0] cycle_count,
    output logic [CNT_WIDTH-1:0] retired_count
);

    state_t state_q;
    state_t state_d;
    ctrl_t  ctrl;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_INIT;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT: state_d = ST_IF;
            ST_IF:   if (mem_ready) state_d = ST_ID;
            ST_ID:   state_d = (opcode == OP_SYSTEM && is_halted) ? ST_HALT : ST_EX;
            ST_EX: begin
                case (opcode)
                    OP_RTYPE, OP_IARITH, OP_JALR: state_d = ST_WB;
                    OP_LOAD, OP_STORE:            state_d = ST_MEM;
                    OP_BRANCH:                    state_d = alu_bcond ? ST_IF : ST_PC_INC;
                    OP_JAL:                       state_d = ST_IF;
                    default:                      state_d = ST_PC_INC;
                endcase
            end
            ST_MEM:    if (mem_ready) state_d = (opcode == OP_LOAD) ? ST_WB : ST_PC_INC;
            ST_WB:     state_d = ST_IF;
            ST_PC_INC: state_d = ST_IF;
            ST_HALT:   state_d = ST_HALT;
            default:   state_d = ST_INIT;
        endcase
    end

    mc_output_decoder u_decoder (
        .state     (state_q),
        .opcode    (opcode),
        .alu_bcond (alu_bcond),
        .mem_ready (mem_ready),
        .ctrl      (ctrl)
    );

    assign pc_write  = ctrl.pc_write;
    assign pc_source = ctrl.pc_source;
    assign i_or_d    = ctrl.i_or_d;
    assign mem_read  = ctrl.mem_read;
    assign mem_write = ctrl.mem_write;
    assign ir_write  = ctrl.ir_write;
    assign reg_write = ctrl.reg_write;
    assign wb_sel    = ctrl.wb_sel;
    assign alu_src_a = ctrl.alu_src_a;
    assign alu_src_b = ctrl.alu_src_b;
    assign alu_op    = ctrl.alu_op;
    assign halted    = ctrl.halted;

`ifdef CONTROL_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] cycle_q;
    logic [CNT_WIDTH-1:0] retired_q;
    logic                 retire;

    // An instruction retires when control returns to fetch from any finishing state.
    assign retire = (state_d == ST_IF) &&
                    (state_q == ST_EX || state_q == ST_WB || state_q == ST_PC_INC);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cycle_q   <= '0;
            retired_q <= '0;
        end else begin
            if (state_q != ST_INIT && state_q != ST_HALT) cycle_q <= cycle_q + 1'b1;
            if (retire) retired_q <= retired_q + 1'b1;
        end
    end

    assign cycle_count   = cycle_q;
    assign retired_count = retired_q;
`else
    assign cycle_count   = '0;
    assign retired_count = '0;
`endif

endmodule

// File: tb/tb_multi_cycle_control_fsm.sv
// Self-checking bench: per-opcode table, randomized instruction timelines
// against an instruction-level model, and hand-written stall/halt/reset cases.
module tb_multi_cycle_control_fsm;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_JR  = 7'b1100111;
    localparam logic [6:0] OP_SYS = 7'b1110011;
    localparam logic [6:0] OP_UNK = 7'b0001111;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [6:0]  opcode;
    logic        alu_bcond, is_halted, mem_ready;
    logic        pc_write, pc_source, i_or_d, mem_read, mem_write, ir_write, reg_write;
    logic [1:0]  wb_sel, alu_src_b, alu_op;
    logic        alu_src_a, halted;
    logic [31:0] cycle_count, retired_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    multi_cycle_control_fsm #(.CNT_WIDTH(32)) dut (
        .clk(clk), .reset_n(reset_n), .opcode(opcode), .alu_bcond(alu_bcond),
        .is_halted(is_halted), .mem_ready(mem_ready), .pc_write(pc_write),
        .pc_source(pc_source), .i_or_d(i_or_d), .mem_read(mem_read),
        .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
        .wb_sel(wb_sel), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .halted(halted), .cycle_count(cycle_count),
        .retired_count(retired_count)
    );

    // Expected strobe vector, fields in order:
    // pc_write pc_source i_or_d mem_read mem_write ir_write reg_write wb_sel alu_src_a alu_src_b alu_op halted
    function automatic logic [14:0] v(input int pcw, pcs, iod, mr, mw, irw, rw, wb, sa, sb, op, h);
        logic [1:0] wb2, sb2, op2;
        wb2 = wb[1:0]; sb2 = sb[1:0]; op2 = op[1:0];
        return {pcw[0], pcs[0], iod[0], mr[0], mw[0], irw[0], rw[0], wb2, sa[0], sb2, op2, h[0]};
    endfunction

    function automatic logic [14:0] outs();
        return {pc_write, pc_source, i_or_d, mem_read, mem_write, ir_write, reg_write,
                wb_sel, alu_src_a, alu_src_b, alu_op, halted};
    endfunction

    task automatic check(input string nm, input logic [14:0] got, input logic [14:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b want %b", nm, got, exp);
        end
    endtask

    task automatic check_cnt(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", nm, got, exp);
        end
    endtask

    // Asserted just after a negedge; returns just after the negedge of the first IF cycle.
    task automatic do_reset(input string nm);
        reset_n = 1'b0;
        #1;
        check({nm, " reset"}, outs(), '0);
        check_cnt({nm, " cyc0"}, cycle_count, 0);
        check_cnt({nm, " ret0"}, retired_count, 0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check({nm, " init"}, outs(), '0);
        @(negedge clk);
    endtask

    typedef struct {
        logic        mr;
        logic [14:0] exp;
    } rec_t;

    rec_t q[$];

    function automatic void push(input logic mr, input logic [14:0] e);
        rec_t r;
        r.mr  = mr;
        r.exp = e;
        q.push_back(r);
    endfunction

    function automatic logic rnd_bit();
        return ($urandom_range(0, 1) == 1);
    endfunction

    // Builds the cycle-by-cycle timeline of one instruction from the ISA-level
    // rules, then plays it against the DUT. Entered and left within an IF cycle.
    task automatic run_instr(input logic [6:0] op, input logic bc, input logic hlt,
                             input int w_if, input int w_mem, output int ncyc);
        logic is_ld, is_st, need_wb, need_inc, need_mem;
        int   wbv, pcs;
        q.delete();
        is_ld = (op == OP_LD);
        is_st = (op == OP_ST);
        need_wb = 0; need_inc = 0; need_mem = 0;
        for (int i = 0; i < w_if; i++) push(1'b0, v(0,0,0,1,0,0,0,0,0,0,0,0));
        push(1'b1, v(0,0,0,1,0,1,0,0,0,0,0,0));
        push(rnd_bit(), v(0,0,0,0,0,0,0,0,0,2,0,0));
        case (op)
            OP_R:         begin push(rnd_bit(), v(0,0,0,0,0,0,0,0,1,0,1,0)); need_wb = 1; end
            OP_I:         begin push(rnd_bit(), v(0,0,0,0,0,0,0,0,1,2,1,0)); need_wb = 1; end
            OP_LD, OP_ST: begin push(rnd_bit(), v(0,0,0,0,0,0,0,0,1,2,0,0)); need_mem = 1; end
            OP_BR:        begin push(rnd_bit(), v(bc,bc,0,0,0,0,0,0,1,0,2,0)); need_inc = !bc; end
            OP_JAL:       push(rnd_bit(), v(1,1,0,0,0,0,1,2,0,1,0,0));
            OP_JR:        begin push(rnd_bit(), v(0,0,0,0,0,0,0,0,1,2,0,0)); need_wb = 1; end
            default:      begin push(rnd_bit(), '0); need_inc = 1; end
        endcase
        if (need_mem) begin
            for (int i = 0; i < w_mem; i++) push(1'b0, v(0,0,1,is_ld,is_st,0,0,0,0,0,0,0));
            push(1'b1, v(0,0,1,is_ld,is_st,0,0,0,0,0,0,0));
            if (is_ld) need_wb = 1; else need_inc = 1;
        end
        if (need_wb) begin
            wbv = is_ld ? 1 : (op == OP_JR) ? 2 : 0;
            pcs = (op == OP_JR) ? 1 : 0;
            push(rnd_bit(), v(1,pcs,0,0,0,0,1,wbv,0,1,0,0));
        end
        if (need_inc) push(rnd_bit(), v(1,0,0,0,0,0,0,0,0,1,0,0));
        foreach (q[i]) begin
            opcode    = op;
            alu_bcond = bc;
            is_halted = hlt;
            mem_ready = q[i].mr;
            #1;
            check($sformatf("op=%b cyc%0d", op, i), outs(), q[i].exp);
            @(negedge clk);
        end
        ncyc = q.size();
    endtask

    typedef struct {
        logic [6:0]  op;
        logic        bc;
        logic [14:0] ex;
        int          len;
    } vec_t;

    vec_t tbl[10];
    logic [6:0] ops[9];

    initial begin
        int n, ncyc, tot_cyc;
        logic [6:0] op;
        logic bc, hlt;

        tbl[0] = '{OP_R,   1'b0, v(0,0,0,0,0,0,0,0,1,0,1,0), 4};
        tbl[1] = '{OP_I,   1'b0, v(0,0,0,0,0,0,0,0,1,2,1,0), 4};
        tbl[2] = '{OP_LD,  1'b0, v(0,0,0,0,0,0,0,0,1,2,0,0), 5};
        tbl[3] = '{OP_ST,  1'b0, v(0,0,0,0,0,0,0,0,1,2,0,0), 5};
        tbl[4] = '{OP_BR,  1'b1, v(1,1,0,0,0,0,0,0,1,0,2,0), 3};
        tbl[5] = '{OP_BR,  1'b0, v(0,0,0,0,0,0,0,0,1,0,2,0), 4};
        tbl[6] = '{OP_JAL, 1'b0, v(1,1,0,0,0,0,1,2,0,1,0,0), 3};
        tbl[7] = '{OP_JR,  1'b0, v(0,0,0,0,0,0,0,0,1,2,0,0), 4};
        tbl[8] = '{OP_SYS, 1'b0, '0, 4};
        tbl[9] = '{OP_UNK, 1'b1, '0, 4};
        ops = '{OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JAL, OP_JR, OP_SYS, OP_UNK};

        reset_n = 1'b0; opcode = '0; alu_bcond = 1'b0; is_halted = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        do_reset("start");

        // Per-opcode EX strobes and instruction latency with an always-ready memory.
        foreach (tbl[k]) begin
            opcode = tbl[k].op; alu_bcond = tbl[k].bc; is_halted = 1'b0; mem_ready = 1'b1;
            #1;
            n = 0;
            forever begin
                if (n == 2) check($sformatf("tbl%0d ex", k), outs(), tbl[k].ex);
                if (n > 0 && mem_read && !i_or_d) break;
                if (n == 20) begin
                    errors++;
                    $display("FAIL tbl%0d timeout: no refetch in %0d cycles", k, n);
                    break;
                end
                @(negedge clk);
                #1;
                n++;
            end
            checks++;
            if (n != tbl[k].len) begin
                errors++;
                $display("FAIL tbl%0d latency: got %0d want %0d", k, n, tbl[k].len);
            end
        end

        // Randomized instruction stream against the timeline model.
        do_reset("rand");
        tot_cyc = 0;
        for (int k = 0; k < 40; k++) begin
            op  = ops[$urandom_range(0, 8)];
            bc  = rnd_bit();
            hlt = (op == OP_SYS) ? 1'b0 : rnd_bit();
            run_instr(op, bc, hlt, $urandom_range(0, 2), $urandom_range(0, 3), ncyc);
            tot_cyc += ncyc;
        end
`ifdef CONTROL_PERF_CNT_EN
        check_cnt("rand cycles", cycle_count, tot_cyc);
        check_cnt("rand retired", retired_count, 40);
`else
        check_cnt("rand cycles", cycle_count, 0);
        check_cnt("rand retired", retired_count, 0);
`endif

        // Load stalled three cycles in MEM, store with fetch stalls.
        run_instr(OP_LD, 1'b0, 1'b0, 0, 3, ncyc);
        run_instr(OP_ST, 1'b1, 1'b0, 2, 2, ncyc);

        // Halting ECALL: ID then HALT for good; reset returns to INIT.
        opcode = OP_SYS; is_halted = 1'b1; mem_ready = 1'b1; alu_bcond = 1'b0;
        #1;
        check("ecall if", outs(), v(0,0,0,1,0,1,0,0,0,0,0,0));
        @(negedge clk); #1;
        check("ecall id", outs(), v(0,0,0,0,0,0,0,0,0,2,0,0));
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            mem_ready = rnd_bit(); is_halted = rnd_bit(); opcode = ops[$urandom_range(0, 8)];
            #1;
            check($sformatf("halt%0d", i), outs(), v(0,0,0,0,0,0,0,0,0,0,0,1));
        end
        is_halted = 1'b0;
        do_reset("after halt");

        // Reset while a store is stalled in MEM drops mem_write without a clock edge.
        opcode = OP_ST; mem_ready = 1'b1;
        @(negedge clk); @(negedge clk); @(negedge clk);
        mem_ready = 1'b0;
        #1;
        check("store stall 0", outs(), v(0,0,1,0,1,0,0,0,0,0,0,0));
        @(negedge clk); #1;
        check("store stall 1", outs(), v(0,0,1,0,1,0,0,0,0,0,0,0));
        do_reset("store");

        // Three R-type instructions then one idle fetch cycle.
        for (int k = 0; k < 3; k++) run_instr(OP_R, 1'b0, 1'b0, 0, 0, ncyc);
        mem_ready = 1'b0;
        @(negedge clk); #1;
        check("refetch wait", outs(), v(0,0,0,1,0,0,0,0,0,0,0,0));
`ifdef CONTROL_PERF_CNT_EN
        check_cnt("3r cycles", cycle_count, 13);
        check_cnt("3r retired", retired_count, 3);
`else
        check_cnt("3r cycles", cycle_count, 0);
        check_cnt("3r retired", retired_count, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
